// File: rtl/sine_pwm_pkg.sv
// Shared FSM state type, default parameter values and duty midpoint helper
// for the multi-channel sine PWM generator.
package sine_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_t;

    localparam int DEF_N_CH     = 3;
    localparam int DEF_PWM_W    = 8;
    localparam int DEF_PHASE_W  = 16;
    localparam int DEF_LUT_AW   = 6;
    localparam int DEF_DEAD_CYC = 2;

    // Duty word for zero sine amplitude: half of the PWM period.
    function automatic int duty_mid(input int pwm_w);
        return 1 << (pwm_w - 1);
    endfunction

endpackage

// File: rtl/sine_lut_q.sv
// Combinational quarter-wave sine ROM, 2^LUT_AW entries of PWM_W-1 bits,
// filled at elaboration with round(A*sin(pi/2*(i+0.5)/2^LUT_AW)).
module sine_lut_q #(
    parameter int PWM_W  = 8,
    parameter int LUT_AW = 6
) (
    input  logic [LUT_AW-1:0] i_idx,
    output logic [PWM_W-2:0]  o_val
);

    localparam int  DEPTH   = 1 << LUT_AW;
    localparam int  AMP     = (1 << (PWM_W - 1)) - 1;
    localparam real HALF_PI = 1.5707963267948966;

    logic [PWM_W-2:0] w_rom [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            // Half-step sample point keeps the table symmetric under mirroring.
            localparam real ANGLE = HALF_PI * (real'(gi) + 0.5) / real'(DEPTH);
            localparam int  ENTRY = $rtoi(real'(AMP) * $sin(ANGLE) + 0.5);
            assign w_rom[gi] = ENTRY[PWM_W-2:0];
        end
    endgenerate

    assign o_val = w_rom[i_idx];

endmodule

// File: rtl/sine_pwm_multi.sv
// Multi-channel DDS sine PWM generator with graceful stop.
// Optional complementary outputs with dead time: define SINE_PWM_COMPL_EN.
module sine_pwm_multi
    import sine_pwm_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int PWM_W   = DEF_PWM_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW
`ifdef SINE_PWM_COMPL_EN
    ,
    parameter int DEAD_CYC = DEF_DEAD_CYC
`endif
) (
    input  logic                    clk_100,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      ftw,
    input  logic [N_CH*PHASE_W-1:0] phase_off,
    output logic [N_CH-1:0]         sine,
    output logic                    period_tick,
    output logic                    busy
`ifdef SINE_PWM_COMPL_EN
    ,
    output logic [N_CH-1:0]         sine_n
`endif
);

    localparam logic [PWM_W-1:0] CNT_MAX  = '1;
    localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(1);
    localparam logic [PWM_W-1:0] DUTY_MID = PWM_W'(duty_mid(PWM_W));

    pwm_state_t              r_state;
    pwm_state_t              w_state_next;
    logic [PWM_W-1:0]        r_cnt;
    logic [PWM_W-1:0]        w_cnt_next;
    logic [PHASE_W-1:0]      r_acc;
    logic [PHASE_W-1:0]      r_ftw;
    logic [N_CH*PHASE_W-1:0] r_off;
    logic [N_CH*PHASE_W-1:0] w_off_next;
    logic                    r_tick;
    logic                    r_busy;
    logic                    w_running;
    logic                    w_period_end;
    logic                    w_load;
    logic                    w_tick_next;
    logic [N_CH-1:0]         w_sine_vec;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A run request in STOP wins over the end-of-period return to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_next = ST_RUN;
            ST_RUN:  if (!en) w_state_next = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    w_state_next = ST_RUN;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_running    = (r_state != ST_IDLE);
        w_period_end = w_running && (r_cnt == CNT_MAX);
        w_load       = !w_running || w_period_end;
        w_cnt_next   = w_running ? (r_cnt + CNT_ONE) : '0;
        w_tick_next  = (w_cnt_next == CNT_MAX);
    end

    assign w_off_next = w_load ? phase_off : r_off;

    // Outputs are registered from the current state and count, so busy and
    // sine trail the FSM by one cycle; period_tick is aligned to cnt.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ftw  <= '0;
            r_off  <= '0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= w_tick_next;
            r_busy <= w_running;
            r_off  <= w_off_next;
            if (w_period_end) begin
                r_acc <= r_acc + r_ftw;
            end
            if (w_load) begin
                r_ftw <= ftw;
            end
        end
    end

`ifdef SINE_PWM_COMPL_EN
    localparam int               LOW_W   = $clog2(DEAD_CYC + 2);
    localparam logic [LOW_W-1:0] LOW_SAT = LOW_W'(DEAD_CYC + 1);
    localparam logic [LOW_W-1:0] LOW_ONE = LOW_W'(1);

    logic [N_CH-1:0] w_sine_n_vec;
`else
    // Single-ended outputs only.
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PHASE_W-1:0] w_phase;
            logic [LUT_AW-1:0]  w_idx;
            logic [PWM_W-2:0]   w_lut;
            logic [PWM_W-1:0]   w_duty_new;
            logic [PWM_W-1:0]   r_duty;
            logic               w_sine_next;
            logic               r_sine;
            logic               w_unused_phase;

            // Duty is computed from the pre-increment accumulator.
            assign w_phase        = r_acc + w_off_next[gi*PHASE_W +: PHASE_W];
            assign w_unused_phase = ^w_phase;
            assign w_idx          = w_phase[PHASE_W-2] ? ~w_phase[PHASE_W-3 -: LUT_AW]
                                                       :  w_phase[PHASE_W-3 -: LUT_AW];

            sine_lut_q #(
                .PWM_W  (PWM_W),
                .LUT_AW (LUT_AW)
            ) u_lut (
                .i_idx (w_idx),
                .o_val (w_lut)
            );

            assign w_duty_new  = w_phase[PHASE_W-1] ? (DUTY_MID - {1'b0, w_lut})
                                                    : (DUTY_MID + {1'b0, w_lut});
            assign w_sine_next = w_running && (r_cnt < r_duty);

            always_ff @(posedge clk_100 or negedge rst_n) begin
                if (!rst_n) begin
                    r_duty <= DUTY_MID;
                    r_sine <= 1'b0;
                end else begin
                    if (w_load) begin
                        r_duty <= w_duty_new;
                    end
                    r_sine <= w_sine_next;
                end
            end

            assign w_sine_vec[gi] = r_sine;

`ifdef SINE_PWM_COMPL_EN
            logic [LOW_W-1:0] r_low_cnt;
            logic [LOW_W-1:0] w_low_next;
            logic             r_sine_n;

            // Counts consecutive low cycles of sine; sine_n rises once the
            // dead time has elapsed and falls together with sine rising.
            always_comb begin
                w_low_next = r_low_cnt;
                if (w_sine_next) begin
                    w_low_next = '0;
                end else if (r_low_cnt != LOW_SAT) begin
                    w_low_next = r_low_cnt + LOW_ONE;
                end
            end

            always_ff @(posedge clk_100 or negedge rst_n) begin
                if (!rst_n) begin
                    r_low_cnt <= '0;
                    r_sine_n  <= 1'b0;
                end else begin
                    r_low_cnt <= w_low_next;
                    r_sine_n  <= w_running && !w_sine_next && (w_low_next == LOW_SAT);
                end
            end

            assign w_sine_n_vec[gi] = r_sine_n;
`endif
        end
    endgenerate

    assign sine        = w_sine_vec;
    assign period_tick = r_tick;
    assign busy        = r_busy;

`ifdef SINE_PWM_COMPL_EN
    assign sine_n = w_sine_n_vec;
`endif

endmodule
